// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver
// ---------------------------------------------------------------------------
// Command front-end for the team's combinational ALU. Commands arrive over a
// valid/ready handshake and address a small local register file. A command
// either loads an immediate or runs an ALU operation. The result is written
// back to the register file and returned over a valid/ready response channel.
//
// Flow:  IDLE --cmd(load)--> RESP --rsp_ready--> IDLE
//        IDLE --cmd(op)----> ISSUE --(1 cycle)--> RESP --rsp_ready--> IDLE
//
// Parameters:
//   data_width  operand/result width; must match the attached ALU
//   NUM_REGS    register-file depth; power of two, >= 2
//
// Ports:
//   clk               rising-edge clock
//   reset_n           synchronous active-low reset
//   cmd_valid/ready   command handshake (ready only in IDLE)
//   cmd_load          1 = load cmd_imm into rd, 0 = ALU op
//   cmd_func          ALU FuncCode, passed through unchanged
//   cmd_rd/rs/rt      destination / operand A / operand B register indices
//   cmd_imm           immediate for loads
//   alu_A/B           operands to the ALU (held outside ISSUE)
//   alu_FuncCode      function code to the ALU (held outside ISSUE)
//   alu_C             ALU result, sampled only at the end of ISSUE
//   alu_OverflowFlag  ALU overflow, sampled only at the end of ISSUE
//   rsp_valid/ready   response handshake
//   rsp_data          ALU result or loaded immediate
//   rsp_overflow      captured overflow (0 for loads)
//
// Optional build macro ALU_CMD_DRIVER_STICKY_OVF_EN adds:
//   clr_sticky        clears sticky_ovf (a simultaneous overflow capture wins)
//   sticky_ovf        set whenever an ALU op captures an overflow
// ---------------------------------------------------------------------------
module alu_cmd_driver #(
    parameter int unsigned data_width = 16,
    parameter int unsigned NUM_REGS   = 4,
    localparam int unsigned RW        = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_load,
    input  logic [3:0]            cmd_func,
    input  logic [RW-1:0]         cmd_rd,
    input  logic [RW-1:0]         cmd_rs,
    input  logic [RW-1:0]         cmd_rt,
    input  logic [data_width-1:0] cmd_imm,

    output logic [data_width-1:0] alu_A,
    output logic [data_width-1:0] alu_B,
    output logic [3:0]            alu_FuncCode,
    input  logic [data_width-1:0] alu_C,
    input  logic                  alu_OverflowFlag,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_data,
    output logic                  rsp_overflow
`ifdef ALU_CMD_DRIVER_STICKY_OVF_EN
    ,
    input  logic                  clr_sticky,
    output logic                  sticky_ovf
`endif
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StResp  = 2'd2
    } state_e;

    state_e                state;
    logic [data_width-1:0] rf [NUM_REGS];
    logic [RW-1:0]         rd_lat;

    // Single-process FSM; every output is a flop so nothing combinational
    // leaks from the command or ALU inputs to the outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Reset aborts whatever is in flight: no write-back, response dropped.
            state        <= StIdle;
            cmd_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_overflow <= 1'b0;
            alu_A        <= '0;
            alu_B        <= '0;
            alu_FuncCode <= '0;
            rd_lat       <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                rf[i] <= '0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (cmd_load) begin
                            rf[cmd_rd]   <= cmd_imm;
                            rsp_data     <= cmd_imm;
                            rsp_overflow <= 1'b0;
                            rsp_valid    <= 1'b1;
                            state        <= StResp;
                        end else begin
                            // Operands are read now, so rd == rs/rt sees the
                            // old value; write-back happens at end of ISSUE.
                            alu_A        <= rf[cmd_rs];
                            alu_B        <= rf[cmd_rt];
                            alu_FuncCode <= cmd_func;
                            rd_lat       <= cmd_rd;
                            state        <= StIssue;
                        end
                    end
                end
                StIssue: begin
                    rf[rd_lat]   <= alu_C;
                    rsp_data     <= alu_C;
                    rsp_overflow <= alu_OverflowFlag;
                    rsp_valid    <= 1'b1;
                    state        <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= StIdle;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= StIdle;
                end
            endcase
        end
    end

`ifdef ALU_CMD_DRIVER_STICKY_OVF_EN
    // A capture of overflow in ISSUE outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sticky_ovf <= 1'b0;
        end else if (state == StIssue && alu_OverflowFlag) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU attached.
`ifndef FUNC_ID
`define FUNC_ID 4'h0
`endif
`ifndef FUNC_ADD
`define FUNC_ADD 4'h2
`endif
`ifndef FUNC_SUB
`define FUNC_SUB 4'h3
`endif

module tb_alu_cmd_driver;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready, cmd_load;
    logic [3:0]    cmd_func;
    logic [1:0]    cmd_rd, cmd_rs, cmd_rt;
    logic [W-1:0]  cmd_imm;
    logic [W-1:0]  alu_A, alu_B, alu_C;
    logic [3:0]    alu_FuncCode;
    logic          alu_OverflowFlag;
    logic          rsp_valid, rsp_ready, rsp_overflow;
    logic [W-1:0]  rsp_data;
`ifdef ALU_CMD_DRIVER_STICKY_OVF_EN
    logic          clr_sticky;
    logic          sticky_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_cmd_driver #(.data_width(W), .NUM_REGS(4)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_load         (cmd_load),
        .cmd_func         (cmd_func),
        .cmd_rd           (cmd_rd),
        .cmd_rs           (cmd_rs),
        .cmd_rt           (cmd_rt),
        .cmd_imm          (cmd_imm),
        .alu_A            (alu_A),
        .alu_B            (alu_B),
        .alu_FuncCode     (alu_FuncCode),
        .alu_C            (alu_C),
        .alu_OverflowFlag (alu_OverflowFlag),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_data         (rsp_data),
        .rsp_overflow     (rsp_overflow)
`ifdef ALU_CMD_DRIVER_STICKY_OVF_EN
        ,
        .clr_sticky       (clr_sticky),
        .sticky_ovf       (sticky_ovf)
`endif
    );

    // Behavioural stand-in for the external ALU (signed overflow on add/sub).
    always_comb begin
        alu_C            = '0;
        alu_OverflowFlag = 1'b0;
        case (alu_FuncCode)
            `FUNC_ID: alu_C = alu_A;
            `FUNC_ADD: begin
                alu_C            = alu_A + alu_B;
                alu_OverflowFlag = (alu_A[W-1] == alu_B[W-1]) && (alu_C[W-1] != alu_A[W-1]);
            end
            `FUNC_SUB: begin
                alu_C            = alu_A - alu_B;
                alu_OverflowFlag = (alu_A[W-1] != alu_B[W-1]) && (alu_C[W-1] != alu_A[W-1]);
            end
            default: alu_C = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a command and wait (bounded) for the accepting edge; returns #1 after it.
    task automatic send_cmd(input logic ld, input logic [3:0] fn, input logic [1:0] rd,
                            input logic [1:0] rs, input logic [1:0] rt, input logic [W-1:0] imm);
        int guard = 0;
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_func  = fn;
        cmd_rd    = rd;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_imm   = imm;
        while (!cmd_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!cmd_ready) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Measure accept-to-valid latency, check the response, then consume it.
    task automatic get_rsp(input string tag, input int exp_lat, input logic [W-1:0] exp_data,
                           input logic exp_ovf);
        int lat;
        @(negedge clk);
        lat = 1;
        while (!rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(rsp_data), 32'(exp_data));
        check({tag, "_ovf"}, 32'(rsp_overflow), 32'(exp_ovf));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic ld, input logic [3:0] fn,
                       input logic [1:0] rd, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [W-1:0] imm, input logic [W-1:0] exp_data, input logic exp_ovf);
        send_cmd(ld, fn, rd, rs, rt, imm);
        get_rsp(tag, ld ? 1 : 2, exp_data, exp_ovf);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmd_valid = 0; cmd_load = 0; cmd_func = 0; cmd_rd = 0; cmd_rs = 0; cmd_rt = 0;
        cmd_imm = 0; rsp_ready = 0;
`ifdef ALU_CMD_DRIVER_STICKY_OVF_EN
        clr_sticky = 0;
`endif
        do_reset();
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
        check("rst_alu_A", 32'(alu_A), 32'd0);
        check("rst_alu_B", 32'(alu_B), 32'd0);
        check("rst_func", 32'(alu_FuncCode), 32'd0);

        // Loads, then signed-overflow add and readback.
        run("ld_r0", 1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 16'h7FFF, 16'h7FFF, 1'b0);
        run("ld_r1", 1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 16'h0001, 16'h0001, 1'b0);
        run("add_ovf", 1'b0, `FUNC_ADD, 2'd2, 2'd0, 2'd1, 16'h0, 16'h8000, 1'b1);
        check("hold_alu_A", 32'(alu_A), 32'h7FFF);
        check("hold_alu_B", 32'(alu_B), 32'h0001);
        check("hold_func", 32'(alu_FuncCode), 32'(`FUNC_ADD));
        run("id_r2", 1'b0, `FUNC_ID, 2'd0, 2'd2, 2'd0, 16'h0, 16'h8000, 1'b0);

        // rd == rs == rt: old value used, result written back.
        run("ld_r1_5", 1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 16'h0005, 16'h0005, 1'b0);
        run("sub_self", 1'b0, `FUNC_SUB, 2'd1, 2'd1, 2'd1, 16'h0, 16'h0000, 1'b0);
        run("id_r1", 1'b0, `FUNC_ID, 2'd0, 2'd1, 2'd0, 16'h0, 16'h0000, 1'b0);

        // Backpressure: response held 5 cycles while a second command waits.
        send_cmd(1'b1, 4'h0, 2'd3, 2'd0, 2'd0, 16'h1234);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = 1'b1; cmd_rd = 2'd2; cmd_imm = 16'hBEEF;
        for (int i = 0; i < 5; i++) begin
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'h1234);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check("bp_release_ready", 32'(cmd_ready), 32'd1);
        check("bp_release_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        get_rsp("bp_next", 1, 16'hBEEF, 1'b0);
        run("id_r2_beef", 1'b0, `FUNC_ID, 2'd0, 2'd2, 2'd0, 16'h0, 16'hBEEF, 1'b0);
        run("id_r3_1234", 1'b0, `FUNC_ID, 2'd0, 2'd3, 2'd0, 16'h0, 16'h1234, 1'b0);

        // Reset during ISSUE of an op targeting r3.
        send_cmd(1'b0, `FUNC_ADD, 2'd3, 2'd0, 2'd1, 16'h0);
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_issue_valid", 32'(rsp_valid), 32'd0);
        check("rst_issue_data", 32'(rsp_data), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 check("rst_issue_ready", 32'(cmd_ready), 32'd1);
        run("rst_r3", 1'b0, `FUNC_ID, 2'd0, 2'd3, 2'd0, 16'h0, 16'h0000, 1'b0);
        run("rst_r0", 1'b0, `FUNC_ID, 2'd0, 2'd0, 2'd0, 16'h0, 16'h0000, 1'b0);

`ifdef ALU_CMD_DRIVER_STICKY_OVF_EN
        check("sticky_rst", 32'(sticky_ovf), 32'd0);
        run("s_ld_r0", 1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 16'h7FFF, 16'h7FFF, 1'b0);
        run("s_ld_r1", 1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 16'h0001, 16'h0001, 1'b0);
        run("s_add_ovf", 1'b0, `FUNC_ADD, 2'd2, 2'd0, 2'd1, 16'h0, 16'h8000, 1'b1);
        check("sticky_set", 32'(sticky_ovf), 32'd1);
        run("s_add_ok", 1'b0, `FUNC_ADD, 2'd3, 2'd1, 2'd1, 16'h0, 16'h0002, 1'b0);
        check("sticky_hold", 32'(sticky_ovf), 32'd1);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        check("sticky_clr", 32'(sticky_ovf), 32'd0);
        send_cmd(1'b0, `FUNC_ADD, 2'd2, 2'd0, 2'd1, 16'h0);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        check("sticky_set_wins", 32'(sticky_ovf), 32'd1);
        get_rsp("s_add_clr", 1, 16'h8000, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
Name: alu_cmd_driver

Overview:
- Sequential command front-end that drives the team's combinational ALU.
- Accepts register-addressed commands over a valid/ready handshake and owns a small register file.
- Issues operands and FuncCode to the ALU, captures C/OverflowFlag, writes the result back and returns it over a valid/ready response channel.
- Sits between the control path and the ALU instance; the ALU is external and connected port-to-port.

Parameters:
- data_width, 16, operand/result width; must match the attached ALU.
- NUM_REGS, 4, register-file depth; power of two, >= 2; index width RW = $clog2(NUM_REGS).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  driver can accept a command.
- cmd_load  input  1  1 = load immediate into rd; 0 = ALU op.
- cmd_func  input  4  FuncCode for the ALU op; opaque to the driver.
- cmd_rd  input  RW  destination register.
- cmd_rs  input  RW  operand A register.
- cmd_rt  input  RW  operand B register.
- cmd_imm  input  data_width  immediate for load.
- alu_A  output  data_width  to ALU A.
- alu_B  output  data_width  to ALU B.
- alu_FuncCode  output  4  to ALU FuncCode.
- alu_C  input  data_width  from ALU C.
- alu_OverflowFlag  input  1  from ALU OverflowFlag.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_data  output  data_width  result (ALU C or loaded immediate).
- rsp_overflow  output  1  captured OverflowFlag; 0 for loads.

Behaviour:
- Reset (reset_n low at a clk edge):
  - State goes to IDLE; all registers and outputs clear to 0: regfile, alu_A, alu_B, alu_FuncCode, rsp_data, rsp_overflow, rsp_valid.
  - cmd_ready = 1 in the cycle after reset is released.
  - Reset in any state aborts the operation: no write-back, pending response dropped.
- States: IDLE, ISSUE, RESP.
- cmd_ready = 1 only in IDLE. Commands presented in other states are not accepted and must be held by the source.
- IDLE + cmd_valid + cmd_load=1:
  - rf[rd] <= cmd_imm; rsp_data <= cmd_imm; rsp_overflow <= 0; go to RESP.
  - rsp_valid is asserted the next cycle.
- IDLE + cmd_valid + cmd_load=0:
  - alu_A <= rf[rs]; alu_B <= rf[rt]; alu_FuncCode <= cmd_func; latch rd; go to ISSUE.
  - rs = rt is legal: both operands read the same register.
- ISSUE, exactly one cycle:
  - ALU outputs settle combinationally.
  - At the clk edge: rsp_data <= alu_C; rsp_overflow <= alu_OverflowFlag; rf[rd] <= alu_C; go to RESP.
- RESP:
  - rsp_valid = 1; rsp_data and rsp_overflow are held stable until accepted.
  - rsp_valid & rsp_ready returns to IDLE; cmd_ready rises the same cycle as the transition edge completes (registered state).
  - No bypass: a command accepted after RESP sees the updated rf.
- Latency:
  - ALU op: accept edge to rsp_valid = 2 cycles.
  - Load: 1 cycle.
  - Max throughput: ALU op 1 per 3 cycles, load 1 per 2 cycles, with rsp_ready held high.
- alu_A, alu_B and alu_FuncCode keep their last values outside ISSUE; the ALU output is ignored outside ISSUE.
- Arithmetic is performed entirely by the ALU. The driver does no width extension or truncation; all paths are data_width.
- rd = rs or rd = rt: operands are read at accept, and write-back occurs at the end of ISSUE, so the old value is used.
- rsp_ready asserted while rsp_valid = 0 has no effect.

Optional Feature:
- Macro: ALU_CMD_DRIVER_STICKY_OVF_EN.
- Defined: adds input clr_sticky (1 bit) and output sticky_ovf (1 bit).
  - sticky_ovf is set at the ISSUE capture edge when alu_OverflowFlag = 1.
  - Cleared by reset or clr_sticky = 1.
  - Set wins over a simultaneous clr_sticky.
  - Reset value 0.
- Not defined: both ports are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then load r0=16'h7FFF and r1=16'h0001 -> each rsp_valid one cycle after accept, rsp_data = immediate, rsp_overflow = 0.
- Using the `FUNC_ADD code, rd=2, rs=0, rt=1 -> rsp_valid 2 cycles after accept, rsp_data = 16'h8000, rsp_overflow = 1; a subsequent `FUNC_ID with rs=2 returns 16'h8000.
- Using the `FUNC_SUB code, rd=1, rs=1, rt=1 with r1=16'h0005 -> rsp_data = 16'h0000, rsp_overflow = 0, r1 = 0 afterwards.
- Hold rsp_ready = 0 for 5 cycles in RESP while cmd_valid = 1 -> cmd_ready stays 0, rsp_data stable, no second command accepted; release -> returns to IDLE, next command accepted.
- Assert reset_n = 0 during ISSUE of an op targeting r3 = 16'h1234 -> next cycle rsp_valid = 0, cmd_ready = 1 after release, r3 reads 0 (regfile cleared, no write-back).
- With ALU_CMD_DRIVER_STICKY_OVF_EN: overflow ADD, then non-overflow ADD -> sticky_ovf stays 1; pulse clr_sticky -> 0; clr_sticky in the same cycle as an overflow capture -> 1.
